// File: rtl/bus_reg_bank.sv
// bus_reg_bank: a bank of NREGS registers, each WIDTH bits, on a shared tri-state CPU bus.
// In each cycle the bank can load one register from the bus, drive one register onto the
// bus, and run one in-place op (INC/DEC/SHL/SHR) on one register. The op sets carry and
// zero flags.
//
// Ports
//   clk      system clock; all state changes on the rising edge
//   clr      synchronous active-high reset; takes priority over load and op
//   bus      shared bus; this block drives r[oe_sel] while oe_n=0, else releases it (Z)
//   ld_n     active-low load enable; r[ld_sel] <= bus
//   ld_sel   load target index
//   oe_n     active-low output enable; puts r[oe_sel] on the bus (combinational)
//   oe_sel   output source index
//   op_en    active-high in-place op enable
//   op_sel   op target index
//   op       00 INC, 01 DEC, 10 SHL (0 into LSB), 11 SHR (0 into MSB)
//   regs     flat debug tap; r[i] sits at bits [i*WIDTH +: WIDTH]
//   cf       carry, borrow or shifted-out bit of the last executed op
//   zf       set when the result of the last executed op was zero
//   collide  high for one cycle after an op was dropped by a load to the same index
module bus_reg_bank #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NREGS = 4,
  parameter int unsigned SEL_W = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic                   clk,
  input  logic                   clr,
  inout  wire  [WIDTH-1:0]       bus,
  input  logic                   ld_n,
  input  logic [SEL_W-1:0]       ld_sel,
  input  logic                   oe_n,
  input  logic [SEL_W-1:0]       oe_sel,
  input  logic                   op_en,
  input  logic [SEL_W-1:0]       op_sel,
  input  logic [1:0]             op,
  output logic [NREGS*WIDTH-1:0] regs,
  output logic                   cf,
  output logic                   zf,
  output logic                   collide
);

  localparam logic [1:0] OpInc = 2'b00;
  localparam logic [1:0] OpDec = 2'b01;
  localparam logic [1:0] OpShl = 2'b10;
  localparam logic [1:0] OpShr = 2'b11;

  logic [WIDTH-1:0] r_q [NREGS];
  logic [WIDTH-1:0] r_d [NREGS];
  logic             cf_q, cf_d;
  logic             zf_q, zf_d;
  logic             collide_q, collide_d;

  // An index is valid only below NREGS. This check matters only when NREGS is not a
  // power of two.
  function automatic logic idx_ok(input logic [SEL_W-1:0] idx);
    return 32'(idx) < NREGS;
  endfunction

  // Bus drive. An out-of-range source index drives zeros so that the bus never floats
  // while oe_n is low.
  logic [WIDTH-1:0] oe_data;

  always_comb begin
    oe_data = '0;
    if (idx_ok(oe_sel)) begin
      oe_data = r_q[oe_sel];
    end
  end

  assign bus = oe_n ? {WIDTH{1'bz}} : oe_data;

  // ALU-lite on the op target register
  logic [WIDTH-1:0] op_src;
  logic [WIDTH-1:0] op_res;
  logic             op_c;
  logic [WIDTH:0]   sum;

  always_comb begin
    op_src = '0;
    if (idx_ok(op_sel)) begin
      op_src = r_q[op_sel];
    end
    sum    = '0;
    op_res = op_src;
    op_c   = 1'b0;
    case (op)
      OpInc: begin
        sum            = {1'b0, op_src} + {{WIDTH{1'b0}}, 1'b1};
        {op_c, op_res} = sum;
      end
      OpDec: begin
        // Bit WIDTH of the extended difference is the borrow out of 0 - 1.
        sum            = {1'b0, op_src} - {{WIDTH{1'b0}}, 1'b1};
        {op_c, op_res} = sum;
      end
      OpShl: begin
        op_c   = op_src[WIDTH-1];
        op_res = {op_src[WIDTH-2:0], 1'b0};
      end
      OpShr: begin
        op_c   = op_src[0];
        op_res = {1'b0, op_src[WIDTH-1:1]};
      end
      default: begin
        op_c   = 1'b0;
        op_res = op_src;
      end
    endcase
  end

  // Next-state logic for the registers and flags
  logic ld_hit;
  logic op_hit;

  assign ld_hit = !ld_n && idx_ok(ld_sel);
  assign op_hit = op_en && idx_ok(op_sel);

  always_comb begin
    r_d       = r_q;
    cf_d      = cf_q;
    zf_d      = zf_q;
    collide_d = 1'b0;
    if (op_hit) begin
      if (ld_hit && (ld_sel == op_sel)) begin
        // A load to the same register wins. The op is dropped and the flags keep
        // their values.
        collide_d = 1'b1;
      end else begin
        r_d[op_sel] = op_res;
        cf_d        = op_c;
        zf_d        = (op_res == '0);
      end
    end
    if (ld_hit) begin
      r_d[ld_sel] = bus;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        r_q[i] <= '0;
      end
      cf_q      <= 1'b0;
      zf_q      <= 1'b0;
      collide_q <= 1'b0;
    end else begin
      r_q       <= r_d;
      cf_q      <= cf_d;
      zf_q      <= zf_d;
      collide_q <= collide_d;
    end
  end

  for (genvar g = 0; g < int'(NREGS); g++) begin : g_tap
    assign regs[g*WIDTH +: WIDTH] = r_q[g];
  end

  assign cf      = cf_q;
  assign zf      = zf_q;
  assign collide = collide_q;

endmodule

// File: tb/tb_bus_reg_bank.sv
// tb_bus_reg_bank: a self-checking bench for bus_reg_bank. It uses two instances:
// 8-bit x 4 registers and 4-bit x 3 registers. Before each edge the bench pushes its
// expected state {collide, zf, cf, regs} onto a scoreboard queue. After the edge it pops
// that entry and compares it with what the DUT shows. Bus checks follow the same pattern
// without an edge.
module tb_bus_reg_bank;

  localparam logic [1:0] OpInc = 2'b00;
  localparam logic [1:0] OpDec = 2'b01;
  localparam logic [1:0] OpShl = 2'b10;
  localparam logic [1:0] OpShr = 2'b11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: WIDTH=8, NREGS=4
  logic        clr_a, ld_n_a, oe_n_a, op_en_a, drv_en_a;
  logic [1:0]  ld_sel_a, oe_sel_a, op_sel_a, op_a;
  logic [7:0]  drv_a;
  wire  [7:0]  bus_a;
  logic [31:0] regs_a;
  logic        cf_a, zf_a, col_a;

  assign bus_a = drv_en_a ? drv_a : 8'bz;

  bus_reg_bank #(.WIDTH(8), .NREGS(4)) dut_a (
    .clk(clk), .clr(clr_a), .bus(bus_a), .ld_n(ld_n_a), .ld_sel(ld_sel_a),
    .oe_n(oe_n_a), .oe_sel(oe_sel_a), .op_en(op_en_a), .op_sel(op_sel_a), .op(op_a),
    .regs(regs_a), .cf(cf_a), .zf(zf_a), .collide(col_a)
  );

  // Instance B: WIDTH=4, NREGS=3 (index 3 is out of range)
  logic        clr_b, ld_n_b, oe_n_b, op_en_b, drv_en_b;
  logic [1:0]  ld_sel_b, oe_sel_b, op_sel_b, op_b;
  logic [3:0]  drv_b;
  wire  [3:0]  bus_b;
  logic [11:0] regs_b;
  logic        cf_b, zf_b, col_b;

  assign bus_b = drv_en_b ? drv_b : 4'bz;

  bus_reg_bank #(.WIDTH(4), .NREGS(3)) dut_b (
    .clk(clk), .clr(clr_b), .bus(bus_b), .ld_n(ld_n_b), .ld_sel(ld_sel_b),
    .oe_n(oe_n_b), .oe_sel(oe_sel_b), .op_en(op_en_b), .op_sel(op_sel_b), .op(op_b),
    .regs(regs_b), .cf(cf_b), .zf(zf_b), .collide(col_b)
  );

  // Expected-state model and scoreboard
  logic [7:0]  em [4];
  logic        ecf, ezf, ecol;
  logic [3:0]  fm [3];
  logic        fcf, fzf, fcol;
  logic [63:0] sb [$];
  logic [63:0] got, exp_v;
  int          checks = 0;
  int          failures = 0;

  function automatic logic [63:0] ea();
    return {29'd0, ecol, ezf, ecf, em[3], em[2], em[1], em[0]};
  endfunction

  function automatic logic [63:0] oa();
    return {29'd0, col_a, zf_a, cf_a, regs_a};
  endfunction

  function automatic logic [63:0] eb();
    return {49'd0, fcol, fzf, fcf, fm[2], fm[1], fm[0]};
  endfunction

  function automatic logic [63:0] ob();
    return {49'd0, col_b, zf_b, cf_b, regs_b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    clr_a = 1'b0; ld_n_a = 1'b1; oe_n_a = 1'b1; op_en_a = 1'b0; drv_en_a = 1'b0;
    ld_sel_a = 2'd0; oe_sel_a = 2'd0; op_sel_a = 2'd0; op_a = OpInc; drv_a = 8'h00;
  endtask

  task automatic idle_b();
    clr_b = 1'b0; ld_n_b = 1'b1; oe_n_b = 1'b1; op_en_b = 1'b0; drv_en_b = 1'b0;
    ld_sel_b = 2'd0; oe_sel_b = 2'd0; op_sel_b = 2'd0; op_b = OpInc; drv_b = 4'h0;
  endtask

  // Stimulus only: the bench drives v and loads it into r[s] over one edge.
  task automatic load_a(input logic [1:0] s, input logic [7:0] v);
    drv_en_a = 1'b1; drv_a = v; ld_n_a = 1'b0; ld_sel_a = s;
    em[s] = v;
    tick();
    idle_a();
  endtask

  task automatic load_b(input logic [1:0] s, input logic [3:0] v);
    drv_en_b = 1'b1; drv_b = v; ld_n_b = 1'b0; ld_sel_b = s;
    fm[s] = v;
    tick();
    idle_b();
  endtask

  task automatic set_op_a(input logic [1:0] s, input logic [1:0] code);
    op_en_a = 1'b1; op_sel_a = s; op_a = code;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) em[i] = 8'h00;
    for (int i = 0; i < 3; i++) fm[i] = 4'h0;
    ecf = 0; ezf = 0; ecol = 0; fcf = 0; fzf = 0; fcol = 0;
    idle_a(); idle_b();
    clr_a = 1'b1; clr_b = 1'b1;
    sb.push_back(ea()); tick(); idle_a(); idle_b();
    exp_v = sb.pop_front(); got = oa(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL reset_init got=%h exp=%h", got, exp_v); end
    exp_v = eb(); got = ob(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL reset_init_b got=%h exp=%h", got, exp_v); end

    load_a(2'd0, 8'h11); load_a(2'd1, 8'h22); load_a(2'd2, 8'h33);
    sb.push_back(ea()); // r3 still 0 here
    drv_en_a = 1'b1; drv_a = 8'h44; ld_n_a = 1'b0; ld_sel_a = 2'd3; em[3] = 8'h44;
    sb.push_back(ea()); tick(); idle_a();
    void'(sb.pop_front());
    exp_v = sb.pop_front(); got = oa(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL reset_preload got=%h exp=%h", got, exp_v); end

    clr_a = 1'b1;
    for (int i = 0; i < 4; i++) em[i] = 8'h00;
    sb.push_back(ea()); tick(); idle_a();
    exp_v = sb.pop_front(); got = oa(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL reset_clear got=%h exp=%h", got, exp_v); end

    clr_a = 1'b1; ld_n_a = 1'b0; ld_sel_a = 2'd0; drv_en_a = 1'b1; drv_a = 8'h5A;
    sb.push_back(ea()); tick(); idle_a();
    exp_v = sb.pop_front(); got = oa(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL reset_over_load got=%h exp=%h", got, exp_v); end
  endtask

  task automatic test_load_drive();
    drv_en_a = 1'b1; drv_a = 8'hAA; ld_n_a = 1'b0; ld_sel_a = 2'd2; em[2] = 8'hAA;
    sb.push_back(ea()); tick(); idle_a();
    exp_v = sb.pop_front(); got = oa(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL load_r2 got=%h exp=%h", got, exp_v); end

    oe_n_a = 1'b0; oe_sel_a = 2'd2;
    sb.push_back({56'd0, 8'hAA}); #1;
    exp_v = sb.pop_front(); got = {56'd0, bus_a}; checks++;
    if (got !== exp_v) begin failures++; $display("FAIL drive_r2 got=%h exp=%h", got, exp_v); end

    oe_sel_a = 2'd0;
    sb.push_back({56'd0, em[0]}); #1;
    exp_v = sb.pop_front(); got = {56'd0, bus_a}; checks++;
    if (got !== exp_v) begin failures++; $display("FAIL drive_follow_sel got=%h exp=%h", got, exp_v); end

    // With oe_n high the bench must be able to drive the bus without contention.
    oe_n_a = 1'b1; oe_sel_a = 2'd2; drv_en_a = 1'b1; drv_a = 8'h55;
    sb.push_back({56'd0, 8'h55}); #1;
    exp_v = sb.pop_front(); got = {56'd0, bus_a}; checks++;
    if (got !== exp_v) begin failures++; $display("FAIL bus_released got=%h exp=%h", got, exp_v); end
    idle_a();
  endtask

  task automatic test_transfer();
    load_a(2'd1, 8'h3C);
    oe_n_a = 1'b0; oe_sel_a = 2'd1; ld_n_a = 1'b0; ld_sel_a = 2'd3; em[3] = 8'h3C;
    sb.push_back(ea()); tick(); idle_a();
    exp_v = sb.pop_front(); got = oa(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL transfer got=%h exp=%h", got, exp_v); end

    oe_n_a = 1'b0; oe_sel_a = 2'd2; ld_n_a = 1'b0; ld_sel_a = 2'd2;
    sb.push_back(ea()); tick(); idle_a();
    exp_v = sb.pop_front(); got = oa(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL self_transfer got=%h exp=%h", got, exp_v); end
  endtask

  task automatic test_ops();
    load_a(2'd0, 8'hFF);
    set_op_a(2'd0, OpInc); em[0] = 8'h00; ecf = 1; ezf = 1;
    sb.push_back(ea()); tick(); idle_a();
    exp_v = sb.pop_front(); got = oa(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL inc_wrap got=%h exp=%h", got, exp_v); end

    set_op_a(2'd0, OpDec); em[0] = 8'hFF; ecf = 1; ezf = 0;
    sb.push_back(ea()); tick(); idle_a();
    exp_v = sb.pop_front(); got = oa(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL dec_borrow got=%h exp=%h", got, exp_v); end

    load_a(2'd0, 8'h81);
    set_op_a(2'd0, OpShl); em[0] = 8'h02; ecf = 1; ezf = 0;
    sb.push_back(ea()); tick(); idle_a();
    exp_v = sb.pop_front(); got = oa(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL shl_msb got=%h exp=%h", got, exp_v); end

    load_a(2'd0, 8'h01);
    set_op_a(2'd0, OpShr); em[0] = 8'h00; ecf = 1; ezf = 1;
    sb.push_back(ea()); tick(); idle_a();
    exp_v = sb.pop_front(); got = oa(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL shr_lsb got=%h exp=%h", got, exp_v); end

    load_a(2'd0, 8'h05);
    set_op_a(2'd0, OpInc); em[0] = 8'h06; ecf = 0; ezf = 0;
    sb.push_back(ea()); tick(); idle_a();
    exp_v = sb.pop_front(); got = oa(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL inc_plain got=%h exp=%h", got, exp_v); end

    load_a(2'd0, 8'h01);
    set_op_a(2'd0, OpDec); em[0] = 8'h00; ecf = 0; ezf = 1;
    sb.push_back(ea()); tick(); idle_a();
    exp_v = sb.pop_front(); got = oa(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL dec_zero got=%h exp=%h", got, exp_v); end
  endtask

  task automatic test_collision();
    load_a(2'd2, 8'h10);
    set_op_a(2'd3, OpInc); em[3] = 8'h3D; ecf = 0; ezf = 0;
    sb.push_back(ea()); tick(); idle_a();
    exp_v = sb.pop_front(); got = oa(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL flags_clear got=%h exp=%h", got, exp_v); end

    drv_en_a = 1'b1; drv_a = 8'h77; ld_n_a = 1'b0; ld_sel_a = 2'd2;
    set_op_a(2'd2, OpInc); em[2] = 8'h77; ecol = 1;
    sb.push_back(ea()); tick(); idle_a();
    exp_v = sb.pop_front(); got = oa(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL collide_same got=%h exp=%h", got, exp_v); end

    ecol = 0;
    sb.push_back(ea()); tick();
    exp_v = sb.pop_front(); got = oa(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL collide_one_cycle got=%h exp=%h", got, exp_v); end

    load_a(2'd1, 8'h05);
    drv_en_a = 1'b1; drv_a = 8'h77; ld_n_a = 1'b0; ld_sel_a = 2'd2;
    set_op_a(2'd1, OpInc); em[1] = 8'h06; ecf = 0; ezf = 0; ecol = 0;
    sb.push_back(ea()); tick(); idle_a();
    exp_v = sb.pop_front(); got = oa(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL collide_diff got=%h exp=%h", got, exp_v); end

    // r0 is 0, so a DEC that was not dropped would set cf. The flags must stay 0/0.
    drv_en_a = 1'b1; drv_a = 8'h99; ld_n_a = 1'b0; ld_sel_a = 2'd0;
    set_op_a(2'd0, OpDec); em[0] = 8'h99; ecol = 1;
    sb.push_back(ea()); tick(); idle_a();
    exp_v = sb.pop_front(); got = oa(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL collide_flags_hold got=%h exp=%h", got, exp_v); end
    ecol = 0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq_val [4];
    logic       seq_cf  [4];
    logic [1:0] seq_op  [4];
    seq_op[0] = OpInc; seq_val[0] = 8'h3E; seq_cf[0] = 0;
    seq_op[1] = OpShl; seq_val[1] = 8'h7C; seq_cf[1] = 0;
    seq_op[2] = OpShl; seq_val[2] = 8'hF8; seq_cf[2] = 0;
    seq_op[3] = OpShl; seq_val[3] = 8'hF0; seq_cf[3] = 1;
    for (int k = 0; k < 4; k++) begin
      set_op_a(2'd3, seq_op[k]); em[3] = seq_val[k]; ecf = seq_cf[k]; ezf = 0;
      sb.push_back(ea()); tick();
      exp_v = sb.pop_front(); got = oa(); checks++;
      if (got !== exp_v) begin
        failures++; $display("FAIL b2b_op%0d got=%h exp=%h", k, got, exp_v);
      end
    end
    clr_a = 1'b1; set_op_a(2'd3, OpInc);
    for (int i = 0; i < 4; i++) em[i] = 8'h00;
    ecf = 0; ezf = 0; ecol = 0;
    sb.push_back(ea()); tick(); idle_a();
    exp_v = sb.pop_front(); got = oa(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL clr_mid_seq got=%h exp=%h", got, exp_v); end
  endtask

  task automatic test_param();
    load_b(2'd0, 4'h1);
    load_b(2'd2, 4'hF);
    drv_en_b = 1'b1; drv_b = 4'hF; ld_n_b = 1'b0; ld_sel_b = 2'd3;
    sb.push_back(eb()); tick(); idle_b();
    exp_v = sb.pop_front(); got = ob(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL oob_load got=%h exp=%h", got, exp_v); end

    oe_n_b = 1'b0; oe_sel_b = 2'd3;
    sb.push_back({60'd0, 4'h0}); #1;
    exp_v = sb.pop_front(); got = {60'd0, bus_b}; checks++;
    if (got !== exp_v) begin failures++; $display("FAIL oob_drive got=%h exp=%h", got, exp_v); end
    idle_b();

    op_en_b = 1'b1; op_sel_b = 2'd2; op_b = OpInc; fm[2] = 4'h0; fcf = 1; fzf = 1;
    sb.push_back(eb()); tick(); idle_b();
    exp_v = sb.pop_front(); got = ob(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL inc_wrap_w4 got=%h exp=%h", got, exp_v); end

    op_en_b = 1'b1; op_sel_b = 2'd3; op_b = OpInc;
    sb.push_back(eb()); tick(); idle_b();
    exp_v = sb.pop_front(); got = ob(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL oob_op got=%h exp=%h", got, exp_v); end

    drv_en_b = 1'b1; drv_b = 4'h9; ld_n_b = 1'b0; ld_sel_b = 2'd3;
    op_en_b = 1'b1; op_sel_b = 2'd3; op_b = OpDec;
    sb.push_back(eb()); tick(); idle_b();
    exp_v = sb.pop_front(); got = ob(); checks++;
    if (got !== exp_v) begin failures++; $display("FAIL oob_no_collide got=%h exp=%h", got, exp_v); end
  endtask

  initial begin
    test_reset();
    test_load_drive();
    test_transfer();
    test_ops();
    test_collision();
    test_back_to_back();
    test_param();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_reg_bank.md
Name: bus_reg_bank

Overview:
- Parametrised successor to the single 8-bit bus register (A/B) of the 8-bit CPU.
- Holds NREGS registers of WIDTH bits on the shared tri-state bus, with one-hot-free selection by index.
- Each cycle it can load one register from the bus, drive one register onto the bus, and run one in-place ALU-lite op (inc/dec/shift) with carry/zero flags.
- Replaces separate A/B instances and lets the controller use scratch registers.

Parameters:
- WIDTH, 8, bits per register and bus width (>=2).
- NREGS, 4, number of registers (2..16).
- SEL_W, $clog2(NREGS) (min 1), index width; derived, do not override.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- clr  input  1  reset; synchronous, active-high.
- bus  inout  WIDTH  shared CPU bus; driven only while oe_n=0, else high-Z.
- ld_n  input  1  active-low load enable; latches bus into r[ld_sel].
- ld_sel  input  SEL_W  load target index.
- oe_n  input  1  active-low output enable; drives r[oe_sel] onto bus.
- oe_sel  input  SEL_W  output source index.
- op_en  input  1  active-high in-place op enable.
- op_sel  input  SEL_W  op target index.
- op  input  2  00 INC, 01 DEC, 10 SHL (0 into LSB), 11 SHR (0 into MSB).
- regs  output  NREGS*WIDTH  flat tap of all registers; r[i] at bits [i*WIDTH +: WIDTH], for display/debug.
- cf  output  1  carry/borrow/shifted-out bit of the last executed op.
- zf  output  1  1 when the result of the last executed op was zero.
- collide  output  1  registered; 1 for one cycle after an op was dropped due to a load to the same index.

Behaviour:
- Reset: clr=1 at a rising edge sets all r[i]=0, cf=0, zf=0, collide=0. Reset overrides load/op in the same cycle. Asserting clr mid-sequence discards that cycle's load/op.
- bus drive: combinational; bus = r[oe_sel] while oe_n=0, else all Z. No clock latency; follows oe_sel/reg changes in the same cycle.
- Load: ld_n=0 at the edge, r[ld_sel] <= bus next cycle. If oe_n=0 simultaneously, the bus carries r[oe_sel], giving a register-to-register transfer in one cycle. With oe_sel==ld_sel the value is unchanged. Load does not touch cf/zf.
- Op: op_en=1 at the edge, r[op_sel] <= result, cf/zf updated, 1-cycle latency.
  - INC: {cf,res} = r+1; cf=1 only on wrap from all-ones to 0.
  - DEC: res = r-1; cf=1 only on borrow from 0 to all-ones.
  - SHL: cf = old MSB.
  - SHR: cf = old LSB.
  - zf = (res==0).
- Simultaneous load and op:
  - Different indices: both take effect.
  - Same index: load wins, op is dropped, cf/zf hold, collide=1 next cycle.
- collide is 0 on every cycle without a same-index clash.
- Out-of-range index (>= NREGS when NREGS is not a power of 2):
  - load ignored;
  - op ignored, flags hold, no collide;
  - oe_n=0 drives all zeros, not Z.
- Flags hold their value on cycles without an executed op.
- No internal state machine beyond the register array and flag/collide registers. All writes are single-cycle.

Test Plan:
- Reset: load r0..r3 with 0x11,0x22,0x33,0x44, then clr=1 for one edge -> regs all 0x00, cf=0, zf=0, collide=0. Also assert clr together with ld_n=0, bus=0x5A -> r stays 0x00.
- Load/drive: tb drives 0xAA with ld_n=0, ld_sel=2, one edge -> r2=0xAA. Release tb driver, oe_n=0, oe_sel=2 -> bus=0xAA same cycle. oe_n=1 -> bus=ZZ.
- Transfer: r1=0x3C, oe_n=0 oe_sel=1, ld_n=0 ld_sel=3, one edge -> r3=0x3C, r1 unchanged.
- Ops: INC on r0=0xFF -> r0=0x00, cf=1, zf=1. DEC on r0=0x00 -> 0xFF, cf=1, zf=0. SHL on 0x81 -> 0x02, cf=1. SHR on 0x01 -> 0x00, cf=1, zf=1.
- Collision: r2=0x10, cf=0, zf=0; same edge ld_n=0 ld_sel=2 bus=0x77 and op_en=1 op_sel=2 op=INC -> r2=0x77, cf/zf unchanged, collide=1 for exactly one cycle. Repeat with op_sel=1 (r1=0x05) -> r2=0x77, r1=0x06, collide=0.
- Parametrisation: WIDTH=4, NREGS=3. Load ld_sel=3 with bus=0xF -> no register changes. oe_sel=3, oe_n=0 -> bus=0x0. INC r2=0xF -> 0x0, cf=1.
